// File: rtl/mux3_1_if.sv
// Operand/result bundle for the registered 3-to-1 word multiplexer.
// The master drives operands and selects; the slave returns the registered result.
interface mux3_1_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             habilita;
  logic [WIDTH-1:0] entradaA;
  logic [WIDTH-1:0] entradaB;
  logic [WIDTH-1:0] entradaC;
  logic             controle1;
  logic             controle2;
  logic [WIDTH-1:0] saida;
  logic             valido;
  logic             erro;

  modport master (
    output habilita,
    output entradaA,
    output entradaB,
    output entradaC,
    output controle1,
    output controle2,
    input  saida,
    input  valido,
    input  erro
  );

  modport slave (
    input  habilita,
    input  entradaA,
    input  entradaB,
    input  entradaC,
    input  controle1,
    input  controle2,
    output saida,
    output valido,
    output erro
  );

endinterface

// File: rtl/mux3_1.sv
// Registered 3-to-1 word multiplexer with one cycle of latency and a load enable.
// Define MUX3_1_SEL_CHECK_EN to flag select 11 as illegal (zero result, erro=1).
module mux3_1 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic     clock,
  input  logic     reset,
  mux3_1_if.slave  bus
);

  logic [WIDTH-1:0] saida_d, saida_q;
  logic             erro_d, erro_q;
  logic             valido_q;

  always_comb begin
    saida_d = '0;
    erro_d  = 1'b0;
    unique case ({bus.controle1, bus.controle2})
      2'b00: saida_d = bus.entradaA;
      2'b01: saida_d = bus.entradaB;
      2'b10: saida_d = bus.entradaC;
      2'b11: begin
`ifdef MUX3_1_SEL_CHECK_EN
        saida_d = '0;
        erro_d  = 1'b1;
`else
        // controle1 has priority, so the illegal code aliases to operand C.
        saida_d = bus.entradaC;
`endif
      end
      default: saida_d = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      saida_q  <= '0;
      valido_q <= 1'b0;
      erro_q   <= 1'b0;
    end else if (bus.habilita) begin
      saida_q  <= saida_d;
      valido_q <= 1'b1;
      erro_q   <= erro_d;
    end
  end

  assign bus.saida  = saida_q;
  assign bus.valido = valido_q;
  assign bus.erro   = erro_q;

endmodule

// File: tb/tb_mux3_1.sv
// Directed self-checking bench for mux3_1; expected values are hand-computed constants.
// Build with or without MUX3_1_SEL_CHECK_EN; the illegal-select expectations follow the macro.
module tb_mux3_1;

  localparam int unsigned WIDTH = 32;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fails;

  mux3_1_if #(.WIDTH(WIDTH)) bus_if ();

  mux3_1 #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [WIDTH-1:0] got,
                           input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [WIDTH-1:0] exp_saida,
                           input logic exp_valido, input logic exp_erro);
    check_val({tag, ".saida"}, bus_if.saida, exp_saida);
    check_val({tag, ".valido"}, {{(WIDTH-1){1'b0}}, bus_if.valido},
              {{(WIDTH-1){1'b0}}, exp_valido});
    check_val({tag, ".erro"}, {{(WIDTH-1){1'b0}}, bus_if.erro},
              {{(WIDTH-1){1'b0}}, exp_erro});
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic hab, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] c, input logic [1:0] sel);
    bus_if.habilita  = hab;
    bus_if.entradaA  = a;
    bus_if.entradaB  = b;
    bus_if.entradaC  = c;
    bus_if.controle1 = sel[1];
    bus_if.controle2 = sel[0];
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;

    // Reset with arbitrary inputs: outputs clear before any clock edge.
    reset = 1'b1;
    drive(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D, 2'b01);
    #1;
    check_out("reset_immediate", 32'd0, 1'b0, 1'b0);
    step();
    check_out("reset_ignores_edge", 32'd0, 1'b0, 1'b0);

    reset = 1'b0;
    drive(1'b1, 32'd8, 32'd10, 32'd11, 2'b00);
    step();
    check_out("sel00", 32'd8, 1'b1, 1'b0);

    drive(1'b1, 32'd8, 32'd10, 32'd11, 2'b01);
    step();
    check_out("sel01", 32'd10, 1'b1, 1'b0);

    drive(1'b1, 32'd40, 32'd13, 32'd15, 2'b10);
    step();
    check_out("sel10", 32'd15, 1'b1, 1'b0);

    drive(1'b1, 32'd40, 32'd13, 32'd15, 2'b11);
    step();
`ifdef MUX3_1_SEL_CHECK_EN
    check_out("sel11_checked", 32'd0, 1'b1, 1'b1);
`else
    check_out("sel11_alias", 32'd15, 1'b1, 1'b0);
`endif

    // Wide operand passes bit-exact; legal select clears any error flag.
    drive(1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0, 2'b01);
    step();
    check_out("sel01_wide", 32'h8000_0001, 1'b1, 1'b0);

    drive(1'b1, 32'd40, 32'd10, 32'd15, 2'b01);
    step();
    check_out("load10", 32'd10, 1'b1, 1'b0);

    // Hold: operand changes with habilita=0 must not reach saida.
    drive(1'b0, 32'd40, 32'd99, 32'd15, 2'b01);
    for (int i = 0; i < 3; i++) begin
      step();
      check_out("hold10", 32'd10, 1'b1, 1'b0);
    end

    drive(1'b1, 32'd40, 32'd99, 32'd15, 2'b01);
    step();
    check_out("reload99", 32'd99, 1'b1, 1'b0);

    drive(1'b1, 32'd40, 32'd13, 32'd15, 2'b10);
    step();
    check_out("preload15", 32'd15, 1'b1, 1'b0);

    // Mid-cycle reset pulse clears outputs immediately.
    drive(1'b0, 32'd8, 32'd13, 32'd15, 2'b00);
    #1;
    reset = 1'b1;
    #1;
    check_out("reset_midstream", 32'd0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    check_out("after_release_noedge", 32'd0, 1'b0, 1'b0);

    drive(1'b1, 32'd8, 32'd13, 32'd15, 2'b00);
    step();
    check_out("first_after_reset", 32'd8, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mux3_1.md
# mux3_1

Registered 3-to-1 word multiplexer in the datapath. It selects one of three WIDTH-bit operands (entradaA, entradaB, entradaC) using two decoded control bits, controle1 and controle2, and registers the result. Typical operand sources are the register file, the immediate path and the ALU/memory paths. One clock edge of latency keeps the selection path off the downstream critical path.

## Interface
Parameters:
- WIDTH, 32, operand and result width in bits.

Ports:
- clock  input  1  rising-edge clock; the block's single clock.
- reset  input  1  asynchronous, active-high reset.
- habilita  input  1  load enable; 1 = capture a new selection on this edge, 0 = hold.
- entradaA  input  WIDTH  operand 0.
- entradaB  input  WIDTH  operand 1.
- entradaC  input  WIDTH  operand 2.
- controle1  input  1  select bit, high priority.
- controle2  input  1  select bit, low priority.
- saida  output  WIDTH  registered selected operand.
- valido  output  1  registered; 1 = saida holds a result captured since the last reset.
- erro  output  1  registered illegal-select flag (see Configuration).

## Operation
- Select decode, {controle1, controle2}:
  - 00 -> entradaA
  - 01 -> entradaB
  - 10 -> entradaC
  - 11 -> illegal; result depends on Configuration.
- No arithmetic, no width conversion: the selected operand passes bit-exact to saida.
- When habilita=1 at a clock edge:
  - saida <= selected operand.
  - valido <= 1.
  - erro <= illegal-select indication for that edge.
- When habilita=0: saida, valido and erro hold their values.
- Inputs are sampled only at the clock edge. Input changes between edges have no effect on the outputs.
- No state machine. The only state is the saida, valido and erro registers.

## Timing
- Reset is asynchronous and active-high. While reset=1:
  - saida = 0, valido = 0, erro = 0, taking effect immediately without waiting for a clock edge.
  - Clock edges and habilita are ignored.
- Reset release: the first rising edge with reset=0 and habilita=1 captures data.
- Reset asserted mid-operation discards the held result immediately; valido drops to 0 in the same cycle.
- Latency is 1 cycle: inputs valid before edge N appear on saida after edge N.
- Throughput is 1 selection per cycle with habilita held at 1.
- Selection and operand change on the same edge: the values sampled at that edge are used; no glitch is visible on saida.

## Configuration
- Macro: MUX3_1_SEL_CHECK_EN.
- Defined:
  - Select 11 captures saida <= 0 and erro <= 1.
  - Any legal select captures erro <= 0.
- Undefined:
  - Select 11 behaves as 10 (controle1 has priority, so saida <= entradaC).
  - erro is tied to 0.
- Port list is identical in both builds.

## Test plan
- Reset asserted with arbitrary inputs -> saida=0, valido=0 and erro=0 immediately, before any clock edge.
- entradaA=8, entradaB=10, entradaC=11, sel 00, habilita=1 -> saida=8 after the next edge, valido=1.
- Same operands, sel 01 -> saida=10 after the next edge. Then entradaA=40, entradaB=13, entradaC=15, sel 10 -> saida=15.
- Operands 40/13/15, sel 11:
  - With MUX3_1_SEL_CHECK_EN: saida=0, erro=1.
  - Without it: saida=15, erro=0.
- saida=10 held, then habilita=0 and entradaB changed to 99 for 3 edges -> saida stays 10. Then habilita=1 -> saida=99 after the next edge.
- Reset pulsed mid-stream between edges while saida=15 -> outputs clear immediately. First edge after release with sel 00 and entradaA=8 -> saida=8, valido=1.
